// File: rtl/frontend_pkg.sv
// Shared types and helpers for the streaming frontend: FSM state encoding,
// default lane geometry and product-width / lane-slice helpers.
package frontend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WT,
    S_WT_WAIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int unsigned DEF_LANES       = 256;
  localparam int unsigned DEF_IA_W        = 17;
  localparam int unsigned DEF_WT_W        = 17;
  localparam int unsigned DEF_ELEM_ADDR_W = 60;
  localparam int unsigned DEF_WT_ADDR_W   = 4;
  localparam int unsigned DEF_IA_ADDR_W   = 11;
  localparam int unsigned DEF_CNT_W       = 11;

  // grp_last + last carried beside each product
  localparam int unsigned SB_FLAG_W = 2;

  function automatic int unsigned prod_w(input int unsigned ia_w, input int unsigned wt_w);
    return ia_w + wt_w;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/frontend_out_fifo.sv
// Two-entry valid/ready FIFO; entry 0 is always the head so the output
// holds stable until popped. Push and pop together while full is legal.
module frontend_out_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    pop   = (cnt_q != 2'd0) && out_ready;
    case ({in_valid, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = in_data;
        else               e1_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = in_data;
        end else begin
          e0_d = e1_q;
          e1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign occupancy = cnt_q;

endmodule

// File: rtl/frontend_stream_ctrl.sv
// Self-sequencing frontend: walks weight-ROM groups and the IA tile, multiplies
// each IA word by the group weight on LANES lanes, and streams products out.
module frontend_stream_ctrl
  import frontend_pkg::*;
#(
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned IA_W        = DEF_IA_W,
  parameter int unsigned WT_W        = DEF_WT_W,
  parameter int unsigned ELEM_ADDR_W = DEF_ELEM_ADDR_W,
  parameter int unsigned WT_ADDR_W   = DEF_WT_ADDR_W,
  parameter int unsigned IA_ADDR_W   = DEF_IA_ADDR_W,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    signed_mode,
  input  logic [WT_ADDR_W-1:0]                    wt_base,
  input  logic [CNT_W-1:0]                        num_wt,
  input  logic [IA_ADDR_W-1:0]                    ia_base,
  input  logic [CNT_W-1:0]                        num_ia,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    wts_rom_en,
  output logic [WT_ADDR_W-1:0]                    wts_rom_addr,
  input  logic [WT_W+ELEM_ADDR_W-1:0]             wts_rom_data,
  output logic                                    ia_ram_en,
  output logic [IA_ADDR_W-1:0]                    ia_ram_addr,
  input  logic [LANES*IA_W-1:0]                   ia_ram_data,
  output logic                                    prod_valid,
  input  logic                                    prod_ready,
  output logic [LANES*prod_w(IA_W, WT_W)-1:0]     product,
  output logic [ELEM_ADDR_W-1:0]                  prod_elem_addr,
  output logic                                    prod_grp_last,
  output logic                                    prod_last
);

  localparam int unsigned PROD_W = prod_w(IA_W, WT_W);
  localparam int unsigned DATA_W = LANES * PROD_W;
  localparam int unsigned PAY_W  = ELEM_ADDR_W + SB_FLAG_W + DATA_W;

  state_e state_q, state_d;

  logic                   sm_q, sm_d;
  logic [WT_ADDR_W-1:0]   wt_base_q, wt_base_d;
  logic [IA_ADDR_W-1:0]   ia_base_q, ia_base_d;
  logic [CNT_W-1:0]       num_wt_q, num_wt_d;
  logic [CNT_W-1:0]       num_ia_q, num_ia_d;
  logic [CNT_W-1:0]       g_q, g_d;
  logic [CNT_W-1:0]       j_q, j_d;
  logic [WT_W-1:0]        wt_q, wt_d;
  logic [ELEM_ADDR_W-1:0] ea_q, ea_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   rd_grp_last_q, rd_grp_last_d;
  logic                   rd_last_q, rd_last_d;

  logic [1:0]        occ;
  logic [1:0]        fill;
  logic              pop;
  logic              can_issue;
  logic              drain_ok;
  logic              iss_grp_last;
  logic              iss_last;
  logic              fifo_valid;
  logic [DATA_W-1:0] lane_prod;
  logic [PAY_W-1:0]  push_data;
  logic [PAY_W-1:0]  head_data;

  // Occupancy after this cycle's push/pop; a new read lands next cycle, so it
  // may only issue when that figure leaves a free slot.
  always_comb begin
    pop       = fifo_valid && prod_ready;
    fill      = occ + {1'b0, rd_vld_q} - {1'b0, pop};
    can_issue = (fill < 2'd2);
    drain_ok  = !rd_vld_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));
    iss_grp_last = (j_q == num_ia_q - CNT_W'(1));
    iss_last     = iss_grp_last && (g_q == num_wt_q - CNT_W'(1));
  end

  always_comb begin
    state_d       = state_q;
    sm_d          = sm_q;
    wt_base_d     = wt_base_q;
    ia_base_d     = ia_base_q;
    num_wt_d      = num_wt_q;
    num_ia_d      = num_ia_q;
    g_d           = g_q;
    j_d           = j_q;
    wt_d          = wt_q;
    ea_d          = ea_q;
    rd_vld_d      = 1'b0;
    rd_grp_last_d = 1'b0;
    rd_last_d     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    wts_rom_en    = 1'b0;
    wts_rom_addr  = '0;
    ia_ram_en     = 1'b0;
    ia_ram_addr   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sm_d      = signed_mode;
          wt_base_d = wt_base;
          ia_base_d = ia_base;
          num_wt_d  = num_wt;
          num_ia_d  = num_ia;
          g_d       = '0;
          j_d       = '0;
          if ((num_wt == '0) || (num_ia == '0)) state_d = S_DRAIN;
          else                                  state_d = S_LOAD_WT;
        end
      end
      S_LOAD_WT: begin
        busy         = 1'b1;
        wts_rom_en   = 1'b1;
        wts_rom_addr = wt_base_q + WT_ADDR_W'(g_q);
        state_d      = S_WT_WAIT;
      end
      S_WT_WAIT: begin
        busy    = 1'b1;
        wt_d    = wts_rom_data[ELEM_ADDR_W +: WT_W];
        ea_d    = wts_rom_data[ELEM_ADDR_W-1:0];
        state_d = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (can_issue) begin
          ia_ram_en     = 1'b1;
          ia_ram_addr   = ia_base_q + IA_ADDR_W'(j_q);
          rd_vld_d      = 1'b1;
          rd_grp_last_d = iss_grp_last;
          rd_last_d     = iss_last;
          if (iss_grp_last) begin
            j_d = '0;
            if (iss_last) begin
              state_d = S_DRAIN;
            end else begin
              g_d     = g_q + CNT_W'(1);
              state_d = S_LOAD_WT;
            end
          end else begin
            j_d = j_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_ok) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sm_q          <= 1'b0;
      wt_base_q     <= '0;
      ia_base_q     <= '0;
      num_wt_q      <= '0;
      num_ia_q      <= '0;
      g_q           <= '0;
      j_q           <= '0;
      wt_q          <= '0;
      ea_q          <= '0;
      rd_vld_q      <= 1'b0;
      rd_grp_last_q <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sm_q          <= sm_d;
      wt_base_q     <= wt_base_d;
      ia_base_q     <= ia_base_d;
      num_wt_q      <= num_wt_d;
      num_ia_q      <= num_ia_d;
      g_q           <= g_d;
      j_q           <= j_d;
      wt_q          <= wt_d;
      ea_q          <= ea_d;
      rd_vld_q      <= rd_vld_d;
      rd_grp_last_q <= rd_grp_last_d;
      rd_last_q     <= rd_last_d;
    end
  end

  // Operands are extended to the full product width (sign or zero per mode),
  // so a plain truncated multiply gives the correct result in both modes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned IA_LSB = lane_lsb(i, IA_W);
    localparam int unsigned P_LSB  = lane_lsb(i, PROD_W);
    logic [IA_W-1:0]   ia_el;
    logic [PROD_W-1:0] ia_ext;
    logic [PROD_W-1:0] wt_ext;
    always_comb begin
      ia_el  = ia_ram_data[IA_LSB +: IA_W];
      ia_ext = {{WT_W{sm_q & ia_el[IA_W-1]}}, ia_el};
      wt_ext = {{IA_W{sm_q & wt_q[WT_W-1]}}, wt_q};
    end
    assign lane_prod[P_LSB +: PROD_W] = ia_ext * wt_ext;
  end

  assign push_data = {ea_q, rd_grp_last_q, rd_last_q, lane_prod};

  frontend_out_fifo #(
    .W(PAY_W)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_vld_q),
    .in_data   (push_data),
    .out_ready (prod_ready),
    .out_valid (fifo_valid),
    .out_data  (head_data),
    .occupancy (occ)
  );

  assign prod_valid     = fifo_valid;
  assign product        = head_data[DATA_W-1:0];
  assign prod_last      = fifo_valid & head_data[DATA_W];
  assign prod_grp_last  = fifo_valid & head_data[DATA_W+1];
  assign prod_elem_addr = head_data[PAY_W-1 -: ELEM_ADDR_W];

endmodule

// File: tb/tb_frontend_stream_ctrl.sv
// Directed bench for frontend_stream_ctrl with LANES=4 and behavioural ROM/RAM.
module tb_frontend_stream_ctrl;

  logic          clock;
  logic          reset;
  logic          start;
  logic          signed_mode;
  logic [3:0]    wt_base;
  logic [10:0]   num_wt;
  logic [10:0]   ia_base;
  logic [10:0]   num_ia;
  logic          busy;
  logic          done;
  logic          wts_rom_en;
  logic [3:0]    wts_rom_addr;
  logic [76:0]   wts_rom_data;
  logic          ia_ram_en;
  logic [10:0]   ia_ram_addr;
  logic [67:0]   ia_ram_data;
  logic          prod_valid;
  logic          prod_ready;
  logic [135:0]  product;
  logic [59:0]   prod_elem_addr;
  logic          prod_grp_last;
  logic          prod_last;

  logic [76:0] rom [0:15];
  logic [67:0] ram [0:2047];

  int n_asserts;
  int n_fail;

  logic [135:0] neg15_all;
  logic [135:0] u3fffe_all;

  frontend_stream_ctrl #(
    .LANES(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .signed_mode    (signed_mode),
    .wt_base        (wt_base),
    .num_wt         (num_wt),
    .ia_base        (ia_base),
    .num_ia         (num_ia),
    .busy           (busy),
    .done           (done),
    .wts_rom_en     (wts_rom_en),
    .wts_rom_addr   (wts_rom_addr),
    .wts_rom_data   (wts_rom_data),
    .ia_ram_en      (ia_ram_en),
    .ia_ram_addr    (ia_ram_addr),
    .ia_ram_data    (ia_ram_data),
    .prod_valid     (prod_valid),
    .prod_ready     (prod_ready),
    .product        (product),
    .prod_elem_addr (prod_elem_addr),
    .prod_grp_last  (prod_grp_last),
    .prod_last      (prod_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wts_rom_en) wts_rom_data <= rom[wts_rom_addr];
    if (ia_ram_en)  ia_ram_data  <= ram[ia_ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [135:0] exp_prod(input int unsigned a, input int unsigned w);
    logic [135:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*34 +: 34] = 34'((a * 16 + i) * w);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_job(input logic sm, input int unsigned wb, input int unsigned nw,
                           input int unsigned ib, input int unsigned ni);
    signed_mode = sm;
    wt_base     = 4'(wb);
    num_wt      = 11'(nw);
    ia_base     = 11'(ib);
    num_ia      = 11'(ni);
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < maxc) begin
      step();
      k++;
    end
    chk("done_seen", done, 1);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wts_en"}, wts_rom_en, 0);
    chk({tag, "_ia_en"}, ia_ram_en, 0);
    chk({tag, "_valid"}, prod_valid, 0);
    chk({tag, "_grp_last"}, prod_grp_last, 0);
    chk({tag, "_last"}, prod_last, 0);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    for (int a = 0; a < 16; a++) rom[a] = '0;
    rom[2] = {17'd3, 60'hABC};
    rom[3] = {17'd5, 60'hDEF};
    rom[8] = {17'd5, 60'h1};
    rom[9] = {17'd2, 60'h2};
    for (int a = 0; a < 2048; a++)
      for (int i = 0; i < 4; i++) ram[a][i*17 +: 17] = 17'(a * 16 + i);
    ram[20] = {4{17'h1FFFD}};
    ram[21] = {4{17'h1FFFF}};
    neg15_all  = {4{34'h3FFFFFFF1}};
    u3fffe_all = {4{34'h0003FFFE}};
    wts_rom_data = '0;
    ia_ram_data  = '0;

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; wt_base = '0; num_wt = '0;
    ia_base = '0; num_ia = '0; prod_ready = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Test 1: one group, three IA words, free-running output
    start_job(1'b0, 2, 1, 5, 3);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_wts_en", wts_rom_en, 1);
    chk("t1_c1_wts_addr", wts_rom_addr, 2);
    chk("t1_c1_ia_en", ia_ram_en, 0);
    step();
    start = 1'b1;
    chk("t1_c2_wts_en", wts_rom_en, 0);
    chk("t1_c2_ia_en", ia_ram_en, 0);
    step();
    start = 1'b0;
    chk("t1_c3_ia_en", ia_ram_en, 1);
    chk("t1_c3_ia_addr", ia_ram_addr, 5);
    chk("t1_c3_valid", prod_valid, 0);
    step();
    chk("t1_c4_ia_addr", ia_ram_addr, 6);
    chk("t1_c4_valid", prod_valid, 0);
    step();
    chk("t1_c5_ia_addr", ia_ram_addr, 7);
    chk("t1_c5_valid", prod_valid, 1);
    chk("t1_c5_prod", product, exp_prod(5, 3));
    chk("t1_c5_ea", prod_elem_addr, 60'hABC);
    chk("t1_c5_last", prod_last, 0);
    step();
    chk("t1_c6_ia_en", ia_ram_en, 0);
    chk("t1_c6_prod", product, exp_prod(6, 3));
    chk("t1_c6_grp_last", prod_grp_last, 0);
    step();
    chk("t1_c7_prod", product, exp_prod(7, 3));
    chk("t1_c7_grp_last", prod_grp_last, 1);
    chk("t1_c7_last", prod_last, 1);
    chk("t1_c7_done", done, 0);
    step();
    chk("t1_c8_done", done, 1);
    chk("t1_c8_busy", busy, 0);
    chk("t1_c8_valid", prod_valid, 0);
    step();
    chk("t1_c9_done", done, 0);
    chk("t1_c9_wts_en", wts_rom_en, 0);
    step();

    // Test 2: two groups, inputs scrambled after start
    start_job(1'b0, 2, 2, 5, 2);
    num_ia = 11'd7; ia_base = 11'd0; wt_base = 4'd0; num_wt = 11'd5;
    chk("t2_c1_wts_addr", wts_rom_addr, 2);
    step();
    step();
    start = 1'b1;
    chk("t2_c3_ia_addr", ia_ram_addr, 5);
    step();
    start = 1'b0;
    chk("t2_c4_ia_addr", ia_ram_addr, 6);
    step();
    chk("t2_c5_wts_en", wts_rom_en, 1);
    chk("t2_c5_wts_addr", wts_rom_addr, 3);
    chk("t2_c5_ia_en", ia_ram_en, 0);
    chk("t2_c5_prod", product, exp_prod(5, 3));
    chk("t2_c5_grp_last", prod_grp_last, 0);
    step();
    chk("t2_c6_ia_en", ia_ram_en, 0);
    chk("t2_c6_prod", product, exp_prod(6, 3));
    chk("t2_c6_ea", prod_elem_addr, 60'hABC);
    chk("t2_c6_grp_last", prod_grp_last, 1);
    chk("t2_c6_last", prod_last, 0);
    step();
    chk("t2_c7_ia_addr", ia_ram_addr, 5);
    chk("t2_c7_ia_en", ia_ram_en, 1);
    chk("t2_c7_valid", prod_valid, 0);
    step();
    chk("t2_c8_ia_addr", ia_ram_addr, 6);
    step();
    chk("t2_c9_prod", product, exp_prod(5, 5));
    chk("t2_c9_ea", prod_elem_addr, 60'hDEF);
    chk("t2_c9_grp_last", prod_grp_last, 0);
    step();
    chk("t2_c10_prod", product, exp_prod(6, 5));
    chk("t2_c10_grp_last", prod_grp_last, 1);
    chk("t2_c10_last", prod_last, 1);
    step();
    chk("t2_c11_done", done, 1);
    step();
    step();

    // Test 3: back-pressure for ten cycles mid-stream
    start_job(1'b0, 2, 1, 5, 6);
    step(); step(); step();
    chk("t3_c4_ia_addr", ia_ram_addr, 6);
    step();
    prod_ready = 1'b0;
    settle();
    chk("t3_c5_valid", prod_valid, 1);
    chk("t3_c5_ia_en", ia_ram_en, 0);
    for (int c = 6; c <= 14; c++) begin
      step();
      chk("t3_stall_ia_en", ia_ram_en, 0);
      chk("t3_stall_valid", prod_valid, 1);
      chk("t3_stall_prod", product, exp_prod(5, 3));
    end
    step();
    prod_ready = 1'b1;
    settle();
    chk("t3_c15_ia_en", ia_ram_en, 1);
    chk("t3_c15_ia_addr", ia_ram_addr, 7);
    chk("t3_c15_prod", product, exp_prod(5, 3));
    step();
    chk("t3_c16_ia_addr", ia_ram_addr, 8);
    chk("t3_c16_prod", product, exp_prod(6, 3));
    step();
    chk("t3_c17_ia_addr", ia_ram_addr, 9);
    chk("t3_c17_prod", product, exp_prod(7, 3));
    step();
    chk("t3_c18_ia_addr", ia_ram_addr, 10);
    chk("t3_c18_prod", product, exp_prod(8, 3));
    step();
    chk("t3_c19_ia_en", ia_ram_en, 0);
    chk("t3_c19_prod", product, exp_prod(9, 3));
    chk("t3_c19_last", prod_last, 0);
    step();
    chk("t3_c20_prod", product, exp_prod(10, 3));
    chk("t3_c20_last", prod_last, 1);
    step();
    chk("t3_c21_done", done, 1);
    step();

    // Test 4: signed and unsigned multiply extremes
    start_job(1'b1, 8, 1, 20, 1);
    step(); step(); step(); step();
    chk("t4_signed_valid", prod_valid, 1);
    chk("t4_signed_prod", product, neg15_all);
    chk("t4_signed_ea", prod_elem_addr, 60'h1);
    chk("t4_signed_last", prod_last, 1);
    wait_done(10);
    start_job(1'b0, 9, 1, 21, 1);
    step(); step(); step(); step();
    chk("t4_unsigned_valid", prod_valid, 1);
    chk("t4_unsigned_prod", product, u3fffe_all);
    wait_done(10);

    // Test 5: empty jobs and start while busy
    start_job(1'b0, 2, 3, 5, 0);
    chk("t5_c1_busy", busy, 1);
    chk("t5_c1_wts_en", wts_rom_en, 0);
    chk("t5_c1_ia_en", ia_ram_en, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_c2_done", done, 1);
    chk("t5_c2_busy", busy, 0);
    chk("t5_c2_wts_en", wts_rom_en, 0);
    step();
    chk("t5_c3_done", done, 0);
    chk("t5_c3_busy", busy, 0);
    start_job(1'b0, 2, 0, 5, 4);
    chk("t5b_c1_wts_en", wts_rom_en, 0);
    chk("t5b_c1_ia_en", ia_ram_en, 0);
    step();
    chk("t5b_c2_done", done, 1);
    step();

    // Test 6: reset during streaming, then a fresh job
    start_job(1'b0, 2, 1, 5, 6);
    step(); step(); step();
    chk("t6_c4_ia_en", ia_ram_en, 1);
    reset = 1'b1;
    step();
    chk_all_zero("t6_reset");
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_idle_done", done, 0);
      chk("t6_idle_valid", prod_valid, 0);
    end
    start_job(1'b0, 2, 1, 5, 3);
    step(); step(); step(); step();
    chk("t6_restart_valid", prod_valid, 1);
    chk("t6_restart_prod", product, exp_prod(5, 3));
    wait_done(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
